gerador_sequencia: RTL and testbench

GERADOR_SEQUENCIA -- requirements
Module: gerador_sequencia

---
 rtl/gerador_pkg.sv | 29 ++
 rtl/lfsr_sequencia.sv | 35 +++
 rtl/gerador_sequencia.sv | 228 ++++++++++++++++++++++
 tb/tb_gerador_sequencia.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gerador_pkg.sv
// gerador_pkg: shared definitions for the sequence-memory game.
//   estado_t      - controller states
//   LFSR_W        - width of the pseudo-random generator
//   LFSR_TAPS     - feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   DEFAULT_SEED  - seed used when the player supplies zero
//   lfsr_next()   - one step of the left-shifting Fibonacci LFSR
package gerador_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GERA,
      MOSTRA_ON,
      MOSTRA_OFF,
      ESPERA,
      COMPARA,
      VENCEU,
      ERRO
   } estado_t;

   localparam int                LFSR_W       = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

   // Shift left, XOR of the tapped bits enters at bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr_sequencia.sv
// lfsr_sequencia: 16-bit Fibonacci LFSR used to fill the symbol memory.
//   clock       in   system clock
//   reset       in   async active-low reset, state returns to RESET_VALUE
//   load        in   load load_value (has priority over enable)
//   enable      in   advance one step
//   load_value  in   value loaded on load
//   state       out  current LFSR contents
module lfsr_sequencia
   import gerador_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_VALUE = DEFAULT_SEED
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              enable,
   input  logic [LFSR_W-1:0] load_value,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= RESET_VALUE;
      end else if (load) begin
         state_reg <= load_value;
      end else if (enable) begin
         state_reg <= lfsr_next(state_reg);
      end
   end

   assign state = state_reg;

endmodule

// File: rtl/gerador_sequencia.sv
// gerador_sequencia: "Simon"-style game controller. Generates a random
// symbol sequence, displays a prefix of it, then checks player input.
//   clock, reset    system clock, async active-low reset
//   iniciar         start/restart request (honoured in IDLE/VENCEU/ERRO)
//   modo            0 = growing sequence, 1 = full sequence every round
//   seed            LFSR seed captured on accepted start (0 -> DEFAULT_SEED)
//   jogada(_valida) player symbol and its one-cycle strobe
//   show_valid/show_symbol  symbol currently lit (symbol 0 when dark)
//   aguardando      waiting for a player symbol
//   rodada          current round length
//   acertou         one-cycle pulse per correct symbol
//   errou/timeout   game lost / lost by inactivity (levels)
//   venceu          full-length sequence reproduced (level)
module gerador_sequencia #(
   parameter int                                 SYM_W          = 2,
   parameter int                                 DEPTH          = 16,
   parameter int                                 ON_CYCLES      = 50_000_000,
   parameter int                                 OFF_CYCLES     = 25_000_000,
   parameter int                                 TIMEOUT_CYCLES = 250_000_000,
   parameter logic [gerador_pkg::LFSR_W-1:0]     DEFAULT_SEED   = gerador_pkg::DEFAULT_SEED
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             iniciar,
   input  logic                             modo,
   input  logic [gerador_pkg::LFSR_W-1:0]   seed,
   input  logic [SYM_W-1:0]                 jogada,
   input  logic                             jogada_valida,
   output logic                             show_valid,
   output logic [SYM_W-1:0]                 show_symbol,
   output logic                             aguardando,
   output logic [$clog2(DEPTH+1)-1:0]       rodada,
   output logic                             acertou,
   output logic                             errou,
   output logic                             timeout,
   output logic                             venceu
);

   import gerador_pkg::*;

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RND_W = $clog2(DEPTH+1);
   localparam int MAX_A = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int MAX_T = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int TMR_W = $clog2(MAX_T + 1);

   estado_t           state_reg,   state_next;
   logic [IDX_W-1:0]  idx_reg,     idx_next;
   logic [TMR_W-1:0]  timer_reg,   timer_next;
   logic [RND_W-1:0]  rodada_reg,  rodada_next;
   logic              modo_reg,    modo_next;
   logic [SYM_W-1:0]  jogada_reg,  jogada_next;
   logic              timeout_reg, timeout_next;

   logic [SYM_W-1:0]  mem [DEPTH];
   logic [SYM_W-1:0]  mem_rd;

   logic [LFSR_W-1:0] lfsr_state;
   logic [LFSR_W-1:0] lfsr_seed;
   logic              lfsr_load;
   logic              lfsr_enable;
   logic              unused_lfsr_bits;

   logic              aceita_inicio;
   logic              ultimo_idx;
   logic              match;

   // ---------------------------------------------------------------- LFSR
   assign aceita_inicio = iniciar &&
                          (state_reg == IDLE || state_reg == VENCEU || state_reg == ERRO);
   assign lfsr_seed     = (seed == '0) ? DEFAULT_SEED : seed;
   assign lfsr_load     = aceita_inicio;
   assign lfsr_enable   = (state_reg == GERA);

   lfsr_sequencia #(
      .RESET_VALUE (DEFAULT_SEED)
   ) u_lfsr (
      .clock      (clock),
      .reset      (reset),
      .load       (lfsr_load),
      .enable     (lfsr_enable),
      .load_value (lfsr_seed),
      .state      (lfsr_state)
   );

   // Only the low bits become symbols; the rest just carry LFSR history.
   assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:SYM_W];

   // ------------------------------------------------------- symbol memory
   // Contents survive reset; GERA rewrites every entry before any read.
   always_ff @(posedge clock) begin
      if (state_reg == GERA) begin
         mem[idx_reg] <= lfsr_state[SYM_W-1:0];
      end
   end

   assign mem_rd     = mem[idx_reg];
   assign ultimo_idx = (RND_W'(idx_reg) == rodada_reg - RND_W'(1));
   assign match      = (jogada_reg == mem_rd);

   // ---------------------------------------------------------- registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         timer_reg   <= '0;
         rodada_reg  <= '0;
         modo_reg    <= 1'b0;
         jogada_reg  <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         timer_reg   <= timer_next;
         rodada_reg  <= rodada_next;
         modo_reg    <= modo_next;
         jogada_reg  <= jogada_next;
         timeout_reg <= timeout_next;
      end
   end

   // ------------------------------------------------- next-state logic
   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      timer_next   = timer_reg;
      rodada_next  = rodada_reg;
      modo_next    = modo_reg;
      jogada_next  = jogada_reg;
      timeout_next = timeout_reg;

      case (state_reg)
         IDLE, VENCEU, ERRO: begin
            if (iniciar) begin
               state_next   = GERA;
               idx_next     = '0;
               timer_next   = '0;
               modo_next    = modo;
               rodada_next  = modo ? RND_W'(DEPTH) : RND_W'(1);
               timeout_next = 1'b0;
            end
         end

         // idx doubles as the write pointer while filling the memory.
         GERA: begin
            if (idx_reg == IDX_W'(DEPTH-1)) begin
               state_next = MOSTRA_ON;
               idx_next   = '0;
               timer_next = '0;
            end else begin
               idx_next = idx_reg + IDX_W'(1);
            end
         end

         MOSTRA_ON: begin
            if (timer_reg == TMR_W'(ON_CYCLES-1)) begin
               state_next = MOSTRA_OFF;
               timer_next = '0;
            end else begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end

         MOSTRA_OFF: begin
            if (timer_reg == TMR_W'(OFF_CYCLES-1)) begin
               timer_next = '0;
               if (ultimo_idx) begin
                  state_next = ESPERA;
                  idx_next   = '0;
               end else begin
                  state_next = MOSTRA_ON;
                  idx_next   = idx_reg + IDX_W'(1);
               end
            end else begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end

         // A strobe on the last allowed cycle still counts as an input.
         ESPERA: begin
            if (jogada_valida) begin
               state_next  = COMPARA;
               jogada_next = jogada;
            end else if (timer_reg == TMR_W'(TIMEOUT_CYCLES-1)) begin
               state_next   = ERRO;
               timeout_next = 1'b1;
            end else begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end

         COMPARA: begin
            timer_next = '0;
            if (!match) begin
               state_next = ERRO;
            end else if (!ultimo_idx) begin
               state_next = ESPERA;
               idx_next   = idx_reg + IDX_W'(1);
            end else if (rodada_reg == RND_W'(DEPTH)) begin
               state_next = VENCEU;
            end else begin
               state_next = MOSTRA_ON;
               idx_next   = '0;
               if (!modo_reg) begin
                  rodada_next = rodada_reg + RND_W'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ outputs
   // acertou/errou are decoded during COMPARA so they appear the cycle
   // right after the player's strobe; errou then stays high in ERRO.
   assign show_valid  = (state_reg == MOSTRA_ON);
   assign show_symbol = show_valid ? mem_rd : '0;
   assign aguardando  = (state_reg == ESPERA);
   assign rodada      = rodada_reg;
   assign acertou     = (state_reg == COMPARA) && match;
   assign errou       = (state_reg == ERRO) || ((state_reg == COMPARA) && !match);
   assign timeout     = timeout_reg;
   assign venceu      = (state_reg == VENCEU);

endmodule

// File: tb/tb_gerador_sequencia.sv
// tb_gerador_sequencia: randomized games against a behavioural model.
// The driver plays games and pushes the expected shows and responses into
// queues; the monitor pops and compares whenever the DUT shows a symbol,
// pulses acertou or raises errou.
module tb_gerador_sequencia;

   localparam int SYM_W = 2;
   localparam int DEPTH = 4;
   localparam int ON_C  = 3;
   localparam int OFF_C = 2;
   localparam int TO_C  = 20;
   localparam int RND_W = $clog2(DEPTH+1);

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              iniciar = 1'b0;
   logic              modo = 1'b0;
   logic [15:0]       seed = 16'h0;
   logic [SYM_W-1:0]  jogada = '0;
   logic              jogada_valida = 1'b0;
   logic              show_valid;
   logic [SYM_W-1:0]  show_symbol;
   logic              aguardando;
   logic [RND_W-1:0]  rodada;
   logic              acertou;
   logic              errou;
   logic              timeout;
   logic              venceu;

   gerador_sequencia #(
      .SYM_W          (SYM_W),
      .DEPTH          (DEPTH),
      .ON_CYCLES      (ON_C),
      .OFF_CYCLES     (OFF_C),
      .TIMEOUT_CYCLES (TO_C),
      .DEFAULT_SEED   (16'hACE1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .iniciar       (iniciar),
      .modo          (modo),
      .seed          (seed),
      .jogada        (jogada),
      .jogada_valida (jogada_valida),
      .show_valid    (show_valid),
      .show_symbol   (show_symbol),
      .aguardando    (aguardando),
      .rodada        (rodada),
      .acertou       (acertou),
      .errou         (errou),
      .timeout       (timeout),
      .venceu        (venceu)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int show_q[$];   // expected displayed symbols, in order
   int resp_q[$];   // expected responses: 0 correct, 1 wrong symbol, 2 timeout

   task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, got, exp, $time);
      end
   endtask

   task automatic report_fail(input string nome);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", nome, $time);
   endtask

   // Reference sequence: LFSR taps 16,14,13,11 written straight from the
   // polynomial; symbol k is the low SYM_W bits of the k-th state.
   function automatic logic [15:0] prox(input logic [15:0] s);
      int   taps[4] = '{16, 14, 13, 11};
      logic fb = 1'b0;
      for (int k = 0; k < 4; k++) fb = fb ^ s[taps[k]-1];
      return (s << 1) | {15'd0, fb};
   endfunction

   // ------------------------------------------------------------ monitor
   int   cyc = 0;
   logic p_show = 0, p_agu = 0, p_jv = 0, p_err = 0;
   int   run_len = 0, run_sym = 0, gap_len = 0, esp_entry = 0;
   bit   in_gap = 0;

   always @(negedge clock) begin
      int e;
      int kind;
      cyc++;
      if (!reset) begin
         p_show = 0; p_agu = 0; p_jv = 0; p_err = 0;
         run_len = 0; in_gap = 0; gap_len = 0;
         show_q.delete();
         resp_q.delete();
      end else begin
         if (show_valid) begin
            if (!p_show) begin
               if (in_gap) check("gap_len", gap_len, OFF_C);
               in_gap  = 0;
               run_len = 1;
               run_sym = show_symbol;
            end else begin
               run_len++;
            end
         end else begin
            if (show_symbol != '0) check("dark_symbol", show_symbol, 0);
            if (p_show) begin
               if (show_q.size() == 0) begin
                  report_fail("show_unexpected");
               end else begin
                  e = show_q.pop_front();
                  $display("show symbol=%0d len=%0d expected symbol=%0d", run_sym, run_len, e);
                  check("show_symbol", run_sym, e);
                  check("show_len", run_len, ON_C);
               end
               in_gap  = 1;
               gap_len = 1;
            end else if (in_gap && !aguardando) begin
               gap_len++;
            end
         end

         if (aguardando && !p_agu) begin
            esp_entry = cyc;
            if (in_gap) check("gap_len", gap_len, OFF_C);
            in_gap = 0;
         end

         if (acertou && errou) report_fail("acertou_and_errou");

         if (acertou) begin
            if (resp_q.size() == 0) begin
               report_fail("acertou_unexpected");
            end else begin
               e = resp_q.pop_front();
               $display("resp acertou rodada=%0d expected kind=%0d", rodada, e);
               check("resp_kind", 0, e);
               check("acertou_latency", p_jv, 1);
            end
         end

         if (errou && !p_err) begin
            kind = timeout ? 2 : 1;
            if (resp_q.size() == 0) begin
               report_fail("errou_unexpected");
            end else begin
               e = resp_q.pop_front();
               $display("resp errou timeout=%0d rodada=%0d expected kind=%0d", timeout, rodada, e);
               check("resp_kind", kind, e);
               if (e == 1) check("errou_latency", p_jv, 1);
               if (e == 2) check("timeout_cycles", cyc - esp_entry, TO_C);
            end
         end

         p_show = show_valid;
         p_agu  = aguardando;
         p_jv   = jogada_valida;
         p_err  = errou;
      end
   end

   // ------------------------------------------------------------- driver
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      iniciar = 1'b0;
      jogada_valida = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Waits for ESPERA; outside it, occasional stray strobes must be ignored.
   task automatic wait_agu(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (aguardando) begin
            ok = 1;
            return;
         end
         jogada_valida = ($urandom_range(7) == 0);
         jogada        = SYM_W'($urandom);
         tick();
         jogada_valida = 1'b0;
      end
      report_fail("wait_aguardando_bound");
   endtask

   task automatic check_queues_empty();
      check("show_q_empty", show_q.size(), 0);
      check("resp_q_empty", resp_q.size(), 0);
   endtask

   // tipo: 0 play to victory, 1 wrong symbol, 2 let the timer expire
   task automatic jogo(input logic [15:0] sd, input bit md, input int f_rod,
                       input int tipo, input int f_idx);
      int         seq[DEPTH];
      logic [15:0] s;
      int         lat, len, nlen, d, nhold;
      bit         ok;

      s = (sd == 16'h0) ? 16'hACE1 : sd;
      for (int k = 0; k < DEPTH; k++) begin
         seq[k] = int'(s[SYM_W-1:0]);
         s = prox(s);
      end
      $display("game seed=%h modo=%0d tipo=%0d rodada_falha=%0d idx_falha=%0d seq=%0d%0d%0d%0d",
               sd, md, tipo, f_rod, f_idx, seq[0], seq[1], seq[2], seq[3]);

      len = md ? DEPTH : 1;
      for (int k = 0; k < len; k++) show_q.push_back(seq[k]);

      // Start; seed/modo changes after the accepted cycle must not matter.
      seed = sd; modo = md; iniciar = 1'b1;
      lat = 0;
      nhold = $urandom_range(1, 4);
      for (int h = 0; h < nhold; h++) begin
         tick();
         lat++;
         seed = 16'($urandom);
      end
      iniciar = 1'b0;
      modo = 1'($urandom);
      while (!show_valid && lat < 50) begin
         tick();
         lat++;
      end
      check("gera_latency", lat, DEPTH + 1);
      check("rodada_start", rodada, len);

      for (int r = 1; r <= DEPTH; r++) begin
         len = md ? DEPTH : r;
         for (int i = 0; i < len; i++) begin
            wait_agu(ok);
            if (!ok) begin
               do_reset();
               return;
            end
            if (i == 0) check("rodada", rodada, len);
            if (r == f_rod && i == f_idx && tipo != 0) begin
               if (tipo == 1) begin
                  resp_q.push_back(1);
                  jogada = SYM_W'(seq[i] ^ int'($urandom_range(1, 3)));
                  jogada_valida = 1'b1;
                  tick();
                  jogada_valida = 1'b0;
               end else begin
                  resp_q.push_back(2);
                  repeat (TO_C + 1) tick();
               end
               tick();
               tick();
               check("errou_level", errou, 1);
               check("timeout_level", timeout, (tipo == 2) ? 1 : 0);
               check("rodada_final", rodada, len);
               check("venceu_on_loss", venceu, 0);
               // Strobes after the loss are ignored; outputs hold.
               for (int k = 0; k < 2; k++) begin
                  jogada = SYM_W'(seq[0]);
                  jogada_valida = 1'b1;
                  tick();
                  jogada_valida = 1'b0;
                  tick();
               end
               check("errou_hold", errou, 1);
               check("aguardando_after_loss", aguardando, 0);
               check_queues_empty();
               return;
            end
            d = ($urandom_range(3) == 0) ? TO_C - 1 : $urandom_range(0, 5);
            repeat (d) tick();
            resp_q.push_back(0);
            if (i == len - 1 && len != DEPTH) begin
               nlen = len + 1;
               for (int k = 0; k < nlen; k++) show_q.push_back(seq[k]);
            end else if (i == len - 1 && md && r < DEPTH && len != DEPTH) begin
               for (int k = 0; k < DEPTH; k++) show_q.push_back(seq[k]);
            end
            jogada = SYM_W'(seq[i]);
            jogada_valida = 1'b1;
            tick();
            jogada_valida = 1'b0;
         end
         if (len == DEPTH) break;
      end

      tick();
      tick();
      check("venceu_level", venceu, 1);
      check("rodada_win", rodada, DEPTH);
      check("errou_on_win", errou, 0);
      jogada_valida = 1'b1;
      tick();
      jogada_valida = 1'b0;
      tick();
      check("venceu_hold", venceu, 1);
      check_queues_empty();
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      bit ok;
      int md, tp, fr, fi;

      #3;
      check("rst_show_valid", show_valid, 0);
      check("rst_show_symbol", show_symbol, 0);
      check("rst_aguardando", aguardando, 0);
      check("rst_rodada", rodada, 0);
      check("rst_acertou", acertou, 0);
      check("rst_errou", errou, 0);
      check("rst_timeout", timeout, 0);
      check("rst_venceu", venceu, 0);
      tick();
      reset = 1'b1;
      tick();

      jogo(16'hACE1, 1'b0, 0, 0, 0);

      // Reset while a symbol is lit: outputs drop within the same cycle.
      seed = 16'h1234; modo = 1'b0; iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      for (int i = 0; i < 20 && !show_valid; i++) tick();
      check("show_before_reset", show_valid, 1);
      tick();
      #2 reset = 1'b0;
      #1;
      check("midshow_show_valid", show_valid, 0);
      check("midshow_show_symbol", show_symbol, 0);
      check("midshow_rodada", rodada, 0);
      check("midshow_aguardando", aguardando, 0);
      check("midshow_flags", {acertou, errou, timeout, venceu}, 0);
      tick();
      reset = 1'b1;
      tick();

      jogo(16'h0000, 1'b0, 0, 0, 0);
      jogo(16'($urandom), 1'b0, 2, 1, $urandom_range(0, 1));
      fr = $urandom_range(1, DEPTH);
      jogo(16'($urandom), 1'b0, fr, 2, $urandom_range(0, fr - 1));
      jogo(16'($urandom), 1'b1, 0, 0, 0);
      jogo(16'($urandom), 1'b1, 1, 1, $urandom_range(0, DEPTH - 1));

      for (int g = 0; g < 5; g++) begin
         md = $urandom_range(0, 1);
         tp = $urandom_range(0, 2);
         fr = md ? 1 : $urandom_range(1, DEPTH);
         fi = $urandom_range(0, (md ? DEPTH : fr) - 1);
         jogo(16'($urandom), 1'(md), fr, tp, fi);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
